// File: rtl/spectrum_smoother.sv
// Post-FFT bar shaper: one bin per clock, it turns magnitudes into saturated bar heights
// that rise at once and fall linearly, plus peak markers that hold for a set time and then fall slowly.
module spectrum_smoother #(
    parameter int N           = 256,
    parameter int IN_W        = 14,
    parameter int H_W         = 9,
    parameter int SHIFT       = 5,
    parameter int MAX_H       = 479,
    parameter int DECAY       = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fft_done,
    input  logic                freeze,
    input  logic [N*IN_W-1:0]   freq_mag,
    output logic [N*H_W-1:0]    bars,
    output logic [N*H_W-1:0]    peaks,
    output logic                busy,
    output logic                frame_done
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [IN_W-1:0]   MAX_H_IN  = IN_W'(MAX_H);
    localparam logic [H_W-1:0]    MAX_H_H   = H_W'(MAX_H);
    localparam logic [H_W-1:0]    DECAY_H   = H_W'(DECAY);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               done_q_reg;
    logic               block_reg;
    logic               busy_reg;
    logic               frame_done_reg;
    logic               start;

    logic [IN_W-1:0]    mag_vals  [N];
    logic [H_W-1:0]     bar_vals  [N];
    logic [H_W-1:0]     peak_vals [N];
    logic [HOLD_W-1:0]  hold_vals [N];

    logic [IN_W-1:0]    mag_sel;
    logic [H_W-1:0]     bar_sel;
    logic [H_W-1:0]     peak_sel;
    logic [HOLD_W-1:0]  hold_sel;
    logic [IN_W-1:0]    scaled;
    logic [H_W-1:0]     target;
    logic [H_W-1:0]     decayed;
    logic [H_W-1:0]     bar_next;
    logic [H_W-1:0]     peak_dec;
    logic [H_W-1:0]     peak_next;
    logic [HOLD_W-1:0]  hold_next;

    // block_reg suppresses a trigger level that was already high across reset;
    // only a genuine low-to-high transition after reset may start a scan.
    assign start      = fft_done & ~done_q_reg & ~block_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            done_q_reg     <= 1'b0;
            block_reg      <= fft_done;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            done_q_reg     <= fft_done;
            frame_done_reg <= 1'b0;
            if (!fft_done) begin
                block_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start && !freeze) begin
                        state_reg      <= SCAN;
                        idx_reg        <= '0;
                        busy_reg       <= 1'b1;
                        frame_done_reg <= (LAST_IDX == '0);
                    end
                end
                SCAN: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        idx_reg        <= idx_reg + 1'b1;
                        frame_done_reg <= (idx_reg == LAST_IDX - 1'b1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mag_sel  = mag_vals[idx_reg];
    assign bar_sel  = bar_vals[idx_reg];
    assign peak_sel = peak_vals[idx_reg];
    assign hold_sel = hold_vals[idx_reg];

    // Saturation is decided on the full-width shifted value so large inputs never wrap.
    always_comb begin
        scaled    = mag_sel >> SHIFT;
        target    = (scaled > MAX_H_IN) ? MAX_H_H : H_W'(scaled);
        decayed   = (bar_sel > DECAY_H) ? bar_sel - DECAY_H : '0;
        bar_next  = (target > decayed) ? target : decayed;
        peak_dec  = peak_sel - 1'b1;
        peak_next = peak_sel;
        hold_next = hold_sel;
        if (bar_next >= peak_sel) begin
            peak_next = bar_next;
            hold_next = HOLD_INIT;
        end else if (hold_sel != '0) begin
            hold_next = hold_sel - HOLD_W'(1);
        end else begin
            peak_next = (peak_dec > bar_next) ? peak_dec : bar_next;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_bin
        logic [H_W-1:0]    bar_reg;
        logic [H_W-1:0]    peak_reg;
        logic [HOLD_W-1:0] hold_reg;
        logic              write_en;

        assign write_en = (state_reg == SCAN) && (idx_reg == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                bar_reg  <= '0;
                peak_reg <= '0;
                hold_reg <= '0;
            end else if (write_en) begin
                bar_reg  <= bar_next;
                peak_reg <= peak_next;
                hold_reg <= hold_next;
            end
        end

        assign mag_vals[gi]               = freq_mag[gi*IN_W +: IN_W];
        assign bar_vals[gi]               = bar_reg;
        assign peak_vals[gi]              = peak_reg;
        assign hold_vals[gi]              = hold_reg;
        assign bars[gi*H_W +: H_W]        = bar_reg;
        assign peaks[gi*H_W +: H_W]       = peak_reg;
    end

endmodule

// File: tb/tb_spectrum_smoother.sv
// Scoreboard bench for spectrum_smoother: a frame-level reference model predicts the bar and peak
// arrays for every accepted scan, and a monitor compares them when the DUT reports frame completion.
module tb_spectrum_smoother;

    localparam int N     = 256;
    localparam int IN_W  = 14;
    localparam int H_W   = 9;
    localparam int MAXH  = 479;

    logic                clk = 1'b0;
    logic                rst;
    logic                fft_done;
    logic                freeze;
    logic [N*IN_W-1:0]   freq_mag;
    logic [N*H_W-1:0]    bars;
    logic [N*H_W-1:0]    peaks;
    logic                busy;
    logic                frame_done;

    always #5 clk = ~clk;

    spectrum_smoother #(
        .N(N), .IN_W(IN_W), .H_W(H_W), .SHIFT(5), .MAX_H(MAXH), .DECAY(4), .HOLD_FRAMES(30)
    ) dut (
        .clk(clk), .rst(rst), .fft_done(fft_done), .freeze(freeze), .freq_mag(freq_mag),
        .bars(bars), .peaks(peaks), .busy(busy), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;
    int frames_pushed = 0;

    int mb [N];
    int mp [N];
    int mh [N];

    logic [N*H_W-1:0] exp_bars_q  [$];
    logic [N*H_W-1:0] exp_peaks_q [$];
    int               exp_start_q [$];
    logic [N*H_W-1:0] zero_vec = '0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_vec(input string name, input logic [N*H_W-1:0] act,
                                      input logic [N*H_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N; i++) begin
                if (act[i*H_W +: H_W] !== exp[i*H_W +: H_W]) begin
                    $display("FAIL %s bin=%0d actual=%0d expected=%0d (cycle %0d)", name, i,
                             act[i*H_W +: H_W], exp[i*H_W +: H_W], cyc);
                    break;
                end
            end
        end
    endfunction

    function automatic int bar_at(input int i);
        return int'(bars[i*H_W +: H_W]);
    endfunction

    function automatic int peak_at(input int i);
        return int'(peaks[i*H_W +: H_W]);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mb[i] = 0;
            mp[i] = 0;
            mh[i] = 0;
        end
    endfunction

    // One whole frame of the bar/peak rules applied to every bin.
    function automatic void model_frame();
        for (int i = 0; i < N; i++) begin
            int t;
            int d;
            int nb;
            t  = int'(freq_mag[i*IN_W +: IN_W]) / 32;
            if (t > MAXH) t = MAXH;
            d  = (mb[i] > 4) ? mb[i] - 4 : 0;
            nb = (t > d) ? t : d;
            mb[i] = nb;
            if (nb >= mp[i]) begin
                mp[i] = nb;
                mh[i] = 30;
            end else if (mh[i] > 0) begin
                mh[i] = mh[i] - 1;
            end else begin
                mp[i] = (mp[i] - 1 > nb) ? mp[i] - 1 : nb;
            end
        end
    endfunction

    function automatic logic [N*H_W-1:0] pack_model(input bit want_peaks);
        logic [N*H_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*H_W +: H_W] = H_W'(want_peaks ? mp[i] : mb[i]);
        return v;
    endfunction

    function automatic void issue_expected(input int start_cycle);
        model_frame();
        exp_bars_q.push_back(pack_model(1'b0));
        exp_peaks_q.push_back(pack_model(1'b1));
        exp_start_q.push_back(start_cycle);
        frames_pushed++;
    endfunction

    // Monitor: frame timing on frame_done, array contents one cycle later, invariant every cycle.
    int               busy_run = 0;
    bit               pending = 1'b0;
    logic [N*H_W-1:0] pend_bars;
    logic [N*H_W-1:0] pend_peaks;

    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
            pending  = 1'b0;
        end else begin
            if (pending) begin
                check_vec("frame_bars", bars, pend_bars);
                check_vec("frame_peaks", peaks, pend_peaks);
                check("busy_after_frame", int'(busy), 0);
                $display("frame %0d compared at cycle %0d", frames_seen, cyc);
                pending = 1'b0;
                frames_seen++;
            end
            begin
                int bad;
                bad = -1;
                for (int i = 0; i < N; i++) begin
                    if (bad < 0 && (peak_at(i) < bar_at(i) || bar_at(i) > MAXH)) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL invariant bin=%0d bar=%0d peak=%0d required peak>=bar and bar<=%0d",
                             bad, bar_at(bad), peak_at(bad), MAXH);
                end
            end
            if (busy) busy_run++;
            if (frame_done) begin
                if (exp_bars_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=frame_done expected=none (cycle %0d)", cyc);
                end else begin
                    int s;
                    pend_bars  = exp_bars_q.pop_front();
                    pend_peaks = exp_peaks_q.pop_front();
                    s          = exp_start_q.pop_front();
                    check("frame_latency", cyc - s, N);
                    check("busy_cycles", busy_run, N);
                    pending = 1'b1;
                end
            end
            if (!busy) busy_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input bit expect_run);
        tick(1);
        fft_done = 1'b1;
        if (expect_run) issue_expected(cyc);
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < 3*N && frames_seen < target; k++) @(posedge clk);
        #1;
        check("frame_arrived", frames_seen, target);
    endtask

    task automatic run_scan();
        start_scan(1'b1);
        tick(1);
        fft_done = 1'b0;
        wait_frames(frames_pushed);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic random_mags();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       freq_mag[i*IN_W +: IN_W] = IN_W'($urandom_range(15296, 16383));
                1:       freq_mag[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 200));
                default: freq_mag[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 16383));
            endcase
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        fft_done = 1'b0;
        freeze   = 1'b0;
        freq_mag = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check_vec("reset_bars", bars, zero_vec);
        check_vec("reset_peaks", peaks, zero_vec);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Ramp: bar k should read k.
        for (int k = 0; k < N; k++) freq_mag[k*IN_W +: IN_W] = IN_W'(k << 5);
        run_scan();
        check("ramp_bar_17", bar_at(17), 17);
        check("ramp_bar_255", bar_at(255), 255);
        check("ramp_peak_255", peak_at(255), 255);

        // Saturation with all ones.
        for (int k = 0; k < N; k++) freq_mag[k*IN_W +: IN_W] = 14'h3FFF;
        run_scan();
        check("sat_bar_0", bar_at(0), MAXH);
        check("sat_peak_200", peak_at(200), MAXH);

        // Randomized frames biased toward the saturation boundary.
        for (int f = 0; f < 6; f++) begin
            random_mags();
            run_scan();
        end

        // Decay and hold on bin 3.
        do_reset();
        tick(1);
        freq_mag = '0;
        freq_mag[3*IN_W +: IN_W] = IN_W'(100 << 5);
        run_scan();
        check("hold_bar3_start", bar_at(3), 100);
        freq_mag = '0;
        for (int f = 1; f <= 40; f++) begin
            run_scan();
            if (f == 1)  check("decay_bar3_f1", bar_at(3), 96);
            if (f == 24) check("decay_bar3_f24", bar_at(3), 4);
            if (f == 25) check("decay_bar3_f25", bar_at(3), 0);
            if (f == 30) check("hold_peak3_f30", peak_at(3), 100);
            if (f == 31) check("fall_peak3_f31", peak_at(3), 99);
            if (f == 40) check("fall_peak3_f40", peak_at(3), 90);
        end

        // Dropped triggers mid-scan and in the frame_done cycle.
        random_mags();
        start_scan(1'b1);
        for (int off = 1; off <= N + 1; off++) begin
            tick(1);
            fft_done = !(off == 50 || off == N - 1 || off == N + 1);
        end
        wait_frames(frames_pushed);
        tick(3);
        check("no_restart_busy", int'(busy), 0);

        // A trigger one cycle after frame_done starts the next scan back-to-back.
        start_scan(1'b1);
        for (int off = 1; off <= N + 2; off++) begin
            tick(1);
            fft_done = (off == N + 1);
            if (off == N + 1) issue_expected(cyc);
        end
        wait_frames(frames_pushed);

        // Freeze in IDLE blocks a scan; freeze raised mid-scan does not.
        freeze = 1'b1;
        tick(2);
        random_mags();
        start_scan(1'b0);
        tick(1);
        fft_done = 1'b0;
        begin
            int bc;
            bc = 0;
            repeat (N + 5) begin
                @(negedge clk);
                bc += int'(busy);
            end
            check("freeze_busy_cycles", bc, 0);
        end
        check_vec("freeze_bars_held", bars, pack_model(1'b0));
        check_vec("freeze_peaks_held", peaks, pack_model(1'b1));
        tick(1);
        freeze = 1'b0;
        start_scan(1'b1);
        tick(1);
        fft_done = 1'b0;
        tick(9);
        freeze = 1'b1;
        wait_frames(frames_pushed);
        freeze = 1'b0;

        // Reset at bin 100 with the trigger held high.
        random_mags();
        start_scan(1'b0);
        tick(101);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_frame_done", int'(frame_done), 0);
        check_vec("abort_bars", bars, zero_vec);
        check_vec("abort_peaks", peaks, zero_vec);
        begin
            int bc;
            bc = 0;
            repeat (20) begin
                @(negedge clk);
                bc += int'(busy);
            end
            check("held_level_no_start", bc, 0);
        end
        tick(1);
        fft_done = 1'b0;
        tick(2);
        run_scan();

        tick(5);
        check("scoreboard_empty", exp_bars_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
